// File: rtl/fix_toe_responder.sv
// fix_toe_responder: TOE-side endpoint for the FIX engine.
//   Answers connect/disconnect requests, frames the outbound FIX byte stream,
//   verifies the tag-10 checksum of every message and reports the verdict.
//   Build option: define FIX_TOE_LOOPBACK_EN to add a byte FIFO that loops
//   accepted bytes back to the engine on message_o/valid_o.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   connect_req_i/addr_i      connect request and requested host
//   disconnect_i/host_num_i   disconnect request and host to drop
//   send_message_valid_i, message_i   outbound byte stream
//   connected_o, connected_host_addr_o  one-cycle connected pulse + host
//   link_up_o                 a host is connected
//   msg_done_o, chk_ok_o, chk_calc_o    end-of-message pulse and checksum result
//   proto_err_o               sticky protocol error
//   message_o, valid_o        loopback byte stream (zero unless loopback built)
module fix_toe_responder #(
  parameter int unsigned CONNECT_LATENCY = 4,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connect_req_i,
  input  logic [1:0] connect_addr_i,
  input  logic       disconnect_i,
  input  logic [1:0] disconnect_host_num_i,
  input  logic       send_message_valid_i,
  input  logic [7:0] message_i,
  output logic       connected_o,
  output logic [1:0] connected_host_addr_o,
  output logic       link_up_o,
  output logic       msg_done_o,
  output logic       chk_ok_o,
  output logic [7:0] chk_calc_o,
  output logic       proto_err_o,
  output logic [7:0] message_o,
  output logic       valid_o
);

  if (CONNECT_LATENCY < 1 || CONNECT_LATENCY > 15) begin : g_bad_latency
    $error("CONNECT_LATENCY must be in 1..15");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StUp   = 2'd2;
  localparam logic [7:0] Soh    = 8'h01;

  // ---------------- connection FSM ----------------
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] addr_q, addr_d;
  logic       connected_q, connected_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    connected_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (connect_req_i) begin
          addr_d  = connect_addr_i;
          cnt_d   = CONNECT_LATENCY[3:0];
          state_d = StWait;
        end
      end
      StWait: begin
        if (disconnect_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          cnt_d       = 4'd0;
          connected_d = 1'b1;
          state_d     = StUp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StUp: begin
        if (disconnect_i && (disconnect_host_num_i == addr_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------- framer ----------------
  logic       up, accept, is_digit, overflow;
  logic [7:0] sum_q, sum_d;     // running sum of the current message
  logic [7:0] fsum_q, fsum_d;   // sum at the start of the current field
  logic [1:0] pos_q, pos_d;     // byte position in field, saturates at 3
  logic       lead1_q, lead1_d, lead10_q, lead10_d;
  logic       trailer_q, trailer_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic [7:0] val_q, val_d;
  logic       done_q, done_d, ok_q, ok_d, perr_q, perr_d;
  logic [7:0] calc_q, calc_d;

  assign up       = (state_q == StUp);
  assign accept   = send_message_valid_i && up;
  assign is_digit = (message_i >= 8'h30) && (message_i <= 8'h39);

  always_comb begin
    sum_d     = sum_q;
    fsum_d    = fsum_q;
    pos_d     = pos_q;
    lead1_d   = lead1_q;
    lead10_d  = lead10_q;
    trailer_d = trailer_q;
    dcnt_d    = dcnt_q;
    val_d     = val_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    calc_d    = calc_q;
    perr_d    = perr_q | overflow | (send_message_valid_i && !up);
    if (!up) begin
      // Any partial message is discarded; the next link-up starts a new field.
      sum_d     = '0;
      pos_d     = '0;
      lead1_d   = 1'b0;
      lead10_d  = 1'b0;
      trailer_d = 1'b0;
      dcnt_d    = '0;
      val_d     = '0;
    end else if (accept) begin
      if (trailer_q) begin
        if (message_i == Soh) begin
          done_d    = 1'b1;
          ok_d      = (val_q == fsum_q);
          calc_d    = fsum_q;
          sum_d     = '0;
          pos_d     = '0;
          lead1_d   = 1'b0;
          lead10_d  = 1'b0;
          trailer_d = 1'b0;
          dcnt_d    = '0;
          val_d     = '0;
        end else if (is_digit && (dcnt_q != 2'd3)) begin
          val_d  = val_q * 8'd10 + (message_i - 8'h30);
          dcnt_d = dcnt_q + 2'd1;
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        sum_d = sum_q + message_i;
        if (message_i == Soh) begin
          pos_d = '0;
        end else begin
          if (pos_q == 2'd0) begin
            fsum_d  = sum_q;
            lead1_d = (message_i == 8'h31);
          end
          if (pos_q == 2'd1) lead10_d = lead1_q && (message_i == 8'h30);
          // fsum_q holds the sum before "1" and stays frozen for the trailer.
          if ((pos_q == 2'd2) && lead10_q && (message_i == 8'h3d)) begin
            trailer_d = 1'b1;
            dcnt_d    = '0;
            val_d     = '0;
          end
          if (pos_q != 2'd3) pos_d = pos_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      connected_q <= 1'b0;
      sum_q       <= '0;
      fsum_q      <= '0;
      pos_q       <= '0;
      lead1_q     <= 1'b0;
      lead10_q    <= 1'b0;
      trailer_q   <= 1'b0;
      dcnt_q      <= '0;
      val_q       <= '0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      calc_q      <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      connected_q <= connected_d;
      sum_q       <= sum_d;
      fsum_q      <= fsum_d;
      pos_q       <= pos_d;
      lead1_q     <= lead1_d;
      lead10_q    <= lead10_d;
      trailer_q   <= trailer_d;
      dcnt_q      <= dcnt_d;
      val_q       <= val_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      calc_q      <= calc_d;
      perr_q      <= perr_d;
    end
  end

  assign connected_o           = connected_q;
  assign connected_host_addr_o = addr_q;
  assign link_up_o             = up && !connected_q;
  assign msg_done_o            = done_q;
  assign chk_ok_o              = ok_q;
  assign chk_calc_o            = calc_q;
  assign proto_err_o           = perr_q;

  // ---------------- loopback FIFO ----------------
`ifdef FIX_TOE_LOOPBACK_EN
  localparam int unsigned Aw = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [Aw-1:0] wr_q, rd_q;
  logic [Aw:0]   fcnt_q;
  logic [7:0]    lb_data_q;
  logic          lb_valid_q;
  logic          full, pop, wr_en;

  assign full     = (fcnt_q == FIFO_DEPTH[Aw:0]);
  assign pop      = (fcnt_q != '0);
  // A pop in the same cycle frees the slot, so push-on-full is not an overflow.
  assign wr_en    = accept && (!full || pop);
  assign overflow = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= message_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      lb_data_q  <= '0;
      lb_valid_q <= 1'b0;
    end else if (!up) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      lb_valid_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + Aw'(1);
      if (pop) begin
        rd_q      <= rd_q + Aw'(1);
        lb_data_q <= mem_q[rd_q];
      end
      lb_valid_q <= pop;
      case ({wr_en, pop})
        2'b10:   fcnt_q <= fcnt_q + (Aw + 1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (Aw + 1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  assign message_o = lb_data_q;
  assign valid_o   = lb_valid_q;
`else
  assign overflow  = 1'b0;
  assign message_o = '0;
  assign valid_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fix_toe_responder.sv
// Testbench for fix_toe_responder: random FIX messages against a scoreboard
// of expected checksum results, plus directed connect/disconnect/reset cases.
module tb_fix_toe_responder;

  localparam int unsigned Lat = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       connect_req = 1'b0;
  logic [1:0] connect_addr = '0;
  logic       disconnect = 1'b0;
  logic [1:0] disconnect_host = '0;
  logic       svalid = 1'b0;
  logic [7:0] sdata = '0;
  logic       connected_o, link_up_o, msg_done_o, chk_ok_o, proto_err_o, valid_o;
  logic [1:0] connected_host_addr_o;
  logic [7:0] chk_calc_o, message_o;

  always #5 clk = ~clk;

  fix_toe_responder #(
    .CONNECT_LATENCY(Lat),
    .FIFO_DEPTH     (16)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .connect_req_i         (connect_req),
    .connect_addr_i        (connect_addr),
    .disconnect_i          (disconnect),
    .disconnect_host_num_i (disconnect_host),
    .send_message_valid_i  (svalid),
    .message_i             (sdata),
    .connected_o           (connected_o),
    .connected_host_addr_o (connected_host_addr_o),
    .link_up_o             (link_up_o),
    .msg_done_o            (msg_done_o),
    .chk_ok_o              (chk_ok_o),
    .chk_calc_o            (chk_calc_o),
    .proto_err_o           (proto_err_o),
    .message_o             (message_o),
    .valid_o               (valid_o)
  );

  typedef struct {
    bit         ok;
    logic [7:0] calc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] lb_q[$];
  int         lb_t[$];
  logic [7:0] msg[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_push = 0;
  int         n_done = 0;
  int         cyc = 0;
  bit         up_exp = 1'b0;
  bit         lb_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation for every msg_done pulse.
  always @(negedge clk) begin
    if (rst && msg_done_o) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_msg_done: got a pulse, expected none (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("chk_ok", {31'd0, chk_ok_o}, {31'd0, mon_e.ok});
        check("chk_calc", {24'd0, chk_calc_o}, {24'd0, mon_e.calc});
      end
    end
`ifdef FIX_TOE_LOOPBACK_EN
    if (rst && valid_o) begin
      if (lb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_loopback: got 0x%0h, expected nothing", message_o);
      end else begin
        check("loopback_data", {24'd0, message_o}, {24'd0, lb_q.pop_front()});
        check("loopback_latency", cyc - lb_t.pop_front(), 2);
      end
    end
`else
    if (valid_o !== 1'b0 || message_o !== 8'h00) lb_bad = 1'b1;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    svalid = 1'b1;
    sdata  = b;
    if (up_exp) begin
      lb_q.push_back(b);
      lb_t.push_back(cyc);
    end
    tick();
    svalid = 1'b0;
    sdata  = '0;
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  // mode 0: correct checksum, 1: "000", 2: random three digits
  task automatic make_msg(input bit rnd, input int mode, output bit ok, output logic [7:0] calc);
    int s;
    int v;
    int nf;
    int tag;
    msg.delete();
    if (!rnd) begin
      add_str("8=FIX.4.2");
      msg.push_back(8'h01);
      add_str("9=5");
      msg.push_back(8'h01);
      add_str("35=0");
      msg.push_back(8'h01);
    end else begin
      nf = int'($urandom_range(1, 6));
      for (int f = 0; f < nf; f++) begin
        tag = int'($urandom_range(1, 999));
        if (tag == 10) tag = 11;
        add_str($sformatf("%0d=", tag));
        for (int j = 0; j < int'($urandom_range(1, 6)); j++)
          msg.push_back(8'($urandom_range(32, 126)));
        msg.push_back(8'h01);
      end
    end
    s = 0;
    foreach (msg[i]) s += int'(msg[i]);
    s = s % 256;
    v = (mode == 0) ? s : (mode == 1) ? 0 : int'($urandom_range(0, 999));
    add_str($sformatf("10=%03d", v));
    msg.push_back(8'h01);
    ok   = ((v % 256) == s);
    calc = 8'(s);
  endtask

  task automatic issue_msg(input bit rnd, input int mode);
    exp_t       e;
    bit         ok;
    logic [7:0] calc;
    make_msg(rnd, mode, ok, calc);
    e.ok   = ok;
    e.calc = calc;
    sb_q.push_back(e);
    n_push++;
    foreach (msg[i]) send_byte(msg[i]);
  endtask

  task automatic do_connect(input logic [1:0] a);
    connect_req  = 1'b1;
    connect_addr = a;
    tick();
    connect_req  = 1'b0;
    connect_addr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit         ok;
    logic [7:0] calc;

    repeat (3) tick();
    check("rst_connected", {31'd0, connected_o}, 0);
    check("rst_host_addr", {30'd0, connected_host_addr_o}, 0);
    check("rst_link_up", {31'd0, link_up_o}, 0);
    check("rst_msg_done", {31'd0, msg_done_o}, 0);
    check("rst_chk_ok", {31'd0, chk_ok_o}, 0);
    check("rst_chk_calc", {24'd0, chk_calc_o}, 0);
    check("rst_proto_err", {31'd0, proto_err_o}, 0);
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_message", {24'd0, message_o}, 0);

    rst = 1'b1;
    tick();

    // Connect: pulse exactly Lat cycles after the request, link_up one later.
    do_connect(2'b10);
    for (int i = 1; i < int'(Lat); i++) begin
      tick();
      check("no_early_connect", {31'd0, connected_o}, 0);
    end
    tick();
    check("connect_pulse", {31'd0, connected_o}, 1);
    check("connect_addr", {30'd0, connected_host_addr_o}, 2);
    check("link_up_during_pulse", {31'd0, link_up_o}, 0);
    tick();
    check("connect_pulse_end", {31'd0, connected_o}, 0);
    check("link_up", {31'd0, link_up_o}, 1);
    up_exp = 1'b1;

    // Directed good and bad-checksum messages, then random back-to-back traffic.
    issue_msg(1'b0, 0);
    issue_msg(1'b0, 1);
    for (int m = 0; m < 40; m++) issue_msg(1'b1, int'($urandom_range(0, 2)));
    repeat (6) tick();
    check("proto_err_clean", {31'd0, proto_err_o}, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    // Disconnect with the wrong host is ignored, the right host drops the link.
    disconnect      = 1'b1;
    disconnect_host = 2'b01;
    tick();
    disconnect = 1'b0;
    tick();
    check("disconnect_wrong_host", {31'd0, link_up_o}, 1);
    disconnect      = 1'b1;
    disconnect_host = 2'b10;
    tick();
    disconnect      = 1'b0;
    disconnect_host = '0;
    up_exp          = 1'b0;
    check("disconnect_link_down", {31'd0, link_up_o}, 0);
    check("no_err_before_byte", {31'd0, proto_err_o}, 0);
    send_byte(8'h41);
    check("byte_while_down", {31'd0, proto_err_o}, 1);

    // Reset in the middle of a message discards it.
    do_connect(2'b01);
    repeat (Lat + 1) tick();
    up_exp = 1'b1;
    make_msg(1'b1, 0, ok, calc);
    for (int i = 0; i < 6; i++) send_byte(msg[i]);
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    up_exp = 1'b0;
    lb_q.delete();
    lb_t.delete();
    check("rst_clears_proto_err", {31'd0, proto_err_o}, 0);
    check("rst_clears_link", {31'd0, link_up_o}, 0);
    do_connect(2'b01);
    repeat (Lat + 1) tick();
    check("reconnect_link_up", {31'd0, link_up_o}, 1);
    up_exp = 1'b1;
    issue_msg(1'b1, 0);
    repeat (6) tick();

    check("final_scoreboard_empty", sb_q.size(), 0);
    check("msg_done_count", n_done, n_push);
    check("final_proto_err", {31'd0, proto_err_o}, 0);
`ifdef FIX_TOE_LOOPBACK_EN
    check("loopback_drained", lb_q.size(), 0);
`else
    check("loopback_tied_off", {31'd0, lb_bad}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
